bus_interface: RTL and testbench
================================

Name: bus_interface

Overview:
- Bridges the CPU's byte-addressed, width-tagged memory requests onto a 32-bit, big-endian, word-addressed bus with per-byte-lane strobes.
- Places write data on the correct lanes and extracts read data from the addressed lanes.
- Flags misaligned or illegal requests.
- Datapath is purely combinational; a small clocked block captures the first faulting request for later diagnosis.

Parameters:
- none

Ports:
- clock  in  1  system clock; only the fault-capture registers use it
- reset  in  1  synchronous, active-high
- cpu_address  in  32  byte address from CPU
- cpu_cycle_width  in  t_cycle_width (2)  CW_BYTE, CW_WORD or CW_LONG
- cpu_data_out  in  32  CPU write data, right-justified (byte in [7:0], word in [15:0])
- cpu_data_in  out  32  read data to CPU, right-justified
- cpu_read  in  1  CPU read request
- cpu_write  in  1  CPU write request
- businterface_address  out  30 ([31:2])  word address; always cpu_address[31:2]
- businterface_data_in  in  32  read data from bus
- businterface_data_out  out  32  write data to bus, lane-placed
- businterface_data_strobes  out  4  lane enables; bit3 = [31:24] … bit0 = [7:0]
- businterface_error  out  1  alignment or illegal-request error
- businterface_read  out  1  bus read
- businterface_write  out  1  bus write
- fault_valid  out  1  sticky flag: an error has occurred since reset
- fault_address  out  32  cpu_address of the first error since reset

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- All outputs except fault_* are combinational from inputs, with zero latency and no reset dependence.
- Lanes are big-endian; a = cpu_address[1:0].
  - Byte: a=0 → lane [31:24], strobe 1000; a=1 → [23:16], 0100; a=2 → [15:8], 0010; a=3 → [7:0], 0001.
  - Word: a=0 → [31:16], strobe 1100; a=2 → [15:0], 0011.
  - Long: a=0 → all lanes, strobe 1111.
- businterface_data_out: the selected lanes carry cpu_data_out's low byte, word or long. All unselected lanes are driven 0xFF.
- cpu_data_in: the selected lanes of businterface_data_in, right-justified. All upper unused bits are 1 (ones-fill, not sign-extension).
- Error condition, evaluated only when cpu_read or cpu_write is 1:
  - word with a[0]=1;
  - long with a≠0;
  - cycle width encoding 2'b11;
  - cpu_read and cpu_write both 1.
- When error = 1:
  - businterface_read = businterface_write = 0;
  - strobes = 0000;
  - businterface_data_out = 0xFFFFFFFF;
  - cpu_data_in = 0xFFFFFFFF.
- When error = 0:
  - businterface_read = cpu_read and businterface_write = cpu_write;
  - strobes are as in the lane table when a request is active, otherwise 0000.
- When neither cpu_read nor cpu_write is asserted: error = 0, strobes = 0000, and lane placement of data still computed.
- Fault capture, sampled on the clock edge:
  - reset → fault_valid = 0 and fault_address = 0;
  - error while fault_valid = 0 → fault_valid = 1 and fault_address = cpu_address;
  - later errors are ignored until reset;
  - reset takes priority over a simultaneous error.

Decomposition:
- Shared package/header (businterface.vh): typedef enum logic [1:0] t_cycle_width with CW_BYTE=2'b00, CW_WORD=2'b01, CW_LONG=2'b10; 2'b11 is reserved and illegal.
- One natural sub-module, bus_lane_steer: combinational lane selection, strobe generation and read-data extraction. The top level adds error gating and fault capture.

Test Plan:
- Byte read, businterface_data_in=0x12345678, cpu_data_out=0xAB, addresses 0..3:
  - cpu_data_in = FFFFFF12 / FFFFFF34 / FFFFFF56 / FFFFFF78;
  - data_out = ABFFFFFF / FFABFFFF / FFFFABFF / FFFFFFAB;
  - strobes = 1000 / 0100 / 0010 / 0001;
  - read=1, write=0, error=0.
- Word read, cpu_data_out=0xABCD, bus data 0x12345678:
  - addr 0 → cpu_data_in FFFF1234, data_out ABCDFFFF, strobes 1100;
  - addr 2 → cpu_data_in FFFF5678, data_out FFFFABCD, strobes 0011.
- Long read at addr 0, cpu_data_out=0xABCDEF12, bus data 0x12345678 → cpu_data_in 12345678, data_out ABCDEF12, strobes 1111, error 0.
- Misaligned read requests → error=1, bus read=0, strobes=0000:
  - word at addr 1 and addr 3;
  - long at addr 1, 2 and 3.
- Fault capture sequence:
  - reset → fault_valid=0;
  - long at 0x00000002 → fault_valid=1, fault_address=0x00000002;
  - word at 0x00000001 on the next cycle → fault_address unchanged;
  - reset → cleared.
- Illegal requests → error=1, businterface_read and businterface_write both 0:
  - cpu_read=cpu_write=1;
  - cycle width 2'b11.

Source files
------------

// File: rtl/bus_interface_pkg.sv
// Shared types and helpers for the CPU-to-bus bridge: cycle width encoding,
// lane fill values and the big-endian strobe map.
package bus_interface_pkg;

    typedef enum logic [1:0] {
        CW_BYTE = 2'b00,
        CW_WORD = 2'b01,
        CW_LONG = 2'b10,
        CW_RSVD = 2'b11
    } t_cycle_width;

    localparam logic [7:0]  FILL_BYTE = 8'hFF;
    localparam logic [31:0] FILL_LONG = 32'hFFFF_FFFF;

    // Big-endian: byte address 0 lives in bits [31:24], hence strobe bit 3.
    function automatic logic [3:0] lane_strobes(input t_cycle_width w, input logic [1:0] a);
        logic [3:0] s;
        case (w)
            CW_BYTE: s = 4'b1000 >> a;
            CW_WORD: s = a[1] ? 4'b0011 : 4'b1100;
            CW_LONG: s = 4'b1111;
            default: s = 4'b0000;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bus_lane_steer.sv
// Combinational lane steering: places CPU write data on the addressed byte
// lanes, extracts right-justified read data and produces raw lane strobes.
module bus_lane_steer
    import bus_interface_pkg::*;
(
    input  logic [1:0]   i_lane,
    input  t_cycle_width i_width,
    input  logic [31:0]  i_cpu_wdata,
    input  logic [31:0]  i_bus_rdata,
    output logic [31:0]  o_bus_wdata,
    output logic [31:0]  o_cpu_rdata,
    output logic [3:0]   o_strobes
);

    // Unselected lanes and unused upper read bits are ones-filled.
    always_comb begin
        o_bus_wdata = FILL_LONG;
        o_cpu_rdata = FILL_LONG;
        case (i_width)
            CW_BYTE: begin
                case (i_lane)
                    2'd0: begin
                        o_bus_wdata[31:24] = i_cpu_wdata[7:0];
                        o_cpu_rdata[7:0]   = i_bus_rdata[31:24];
                    end
                    2'd1: begin
                        o_bus_wdata[23:16] = i_cpu_wdata[7:0];
                        o_cpu_rdata[7:0]   = i_bus_rdata[23:16];
                    end
                    2'd2: begin
                        o_bus_wdata[15:8]  = i_cpu_wdata[7:0];
                        o_cpu_rdata[7:0]   = i_bus_rdata[15:8];
                    end
                    default: begin
                        o_bus_wdata[7:0]   = i_cpu_wdata[7:0];
                        o_cpu_rdata[7:0]   = i_bus_rdata[7:0];
                    end
                endcase
            end
            CW_WORD: begin
                // Only a[1] picks the half; a[0] is flagged upstream as misaligned.
                if (i_lane[1]) begin
                    o_bus_wdata[15:0] = i_cpu_wdata[15:0];
                    o_cpu_rdata[15:0] = i_bus_rdata[15:0];
                end else begin
                    o_bus_wdata[31:16] = i_cpu_wdata[15:0];
                    o_cpu_rdata[15:0]  = i_bus_rdata[31:16];
                end
            end
            CW_LONG: begin
                o_bus_wdata = i_cpu_wdata;
                o_cpu_rdata = i_bus_rdata;
            end
            default: begin
                o_bus_wdata = FILL_LONG;
                o_cpu_rdata = FILL_LONG;
            end
        endcase
    end

    assign o_strobes = lane_strobes(i_width, i_lane);

endmodule

// File: rtl/bus_interface.sv
// CPU-to-bus bridge top: lane steering, request error gating and capture of
// the first faulting address since reset.
module bus_interface
    import bus_interface_pkg::*;
(
    input  logic         clock,
    input  logic         reset,
    input  logic [31:0]  cpu_address,
    input  t_cycle_width cpu_cycle_width,
    input  logic [31:0]  cpu_data_out,
    output logic [31:0]  cpu_data_in,
    input  logic         cpu_read,
    input  logic         cpu_write,
    output logic [31:2]  businterface_address,
    input  logic [31:0]  businterface_data_in,
    output logic [31:0]  businterface_data_out,
    output logic [3:0]   businterface_data_strobes,
    output logic         businterface_error,
    output logic         businterface_read,
    output logic         businterface_write,
    output logic         fault_valid,
    output logic [31:0]  fault_address
);

    logic [31:0] w_lane_wdata;
    logic [31:0] w_lane_rdata;
    logic [3:0]  w_lane_strobes;
    logic        w_request;
    logic        w_misaligned;
    logic        w_illegal;
    logic        w_error;
    logic        r_fault_valid;
    logic [31:0] r_fault_address;

    bus_lane_steer u_steer (
        .i_lane      (cpu_address[1:0]),
        .i_width     (cpu_cycle_width),
        .i_cpu_wdata (cpu_data_out),
        .i_bus_rdata (businterface_data_in),
        .o_bus_wdata (w_lane_wdata),
        .o_cpu_rdata (w_lane_rdata),
        .o_strobes   (w_lane_strobes)
    );

    assign w_request    = cpu_read | cpu_write;
    assign w_misaligned = ((cpu_cycle_width == CW_WORD) && cpu_address[0])
                        | ((cpu_cycle_width == CW_LONG) && (cpu_address[1:0] != 2'b00));
    assign w_illegal    = (cpu_cycle_width == CW_RSVD) | (cpu_read & cpu_write);
    assign w_error      = w_request & (w_misaligned | w_illegal);

    assign businterface_address      = cpu_address[31:2];
    assign businterface_error        = w_error;
    assign businterface_read         = cpu_read  & ~w_error;
    assign businterface_write        = cpu_write & ~w_error;
    assign businterface_data_strobes = (w_request && !w_error) ? w_lane_strobes : 4'b0000;
    assign businterface_data_out     = w_error ? FILL_LONG : w_lane_wdata;
    assign cpu_data_in               = w_error ? FILL_LONG : w_lane_rdata;

    // Sticky capture: only the first error after reset is recorded.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_fault_valid   <= 1'b0;
            r_fault_address <= 32'h0;
        end else if (w_error && !r_fault_valid) begin
            r_fault_valid   <= 1'b1;
            r_fault_address <= cpu_address;
        end
    end

    assign fault_valid   = r_fault_valid;
    assign fault_address = r_fault_address;

endmodule

// File: tb/tb_bus_interface.sv
// Self-checking bench for bus_interface: directed plan steps followed by
// randomized requests compared against a byte-array reference model.
module tb_bus_interface;
    import bus_interface_pkg::*;

    logic         clock = 1'b0;
    logic         reset;
    logic [31:0]  cpu_address;
    t_cycle_width cpu_cycle_width;
    logic [31:0]  cpu_data_out;
    logic [31:0]  cpu_data_in;
    logic         cpu_read;
    logic         cpu_write;
    logic [31:2]  businterface_address;
    logic [31:0]  businterface_data_in;
    logic [31:0]  businterface_data_out;
    logic [3:0]   businterface_data_strobes;
    logic         businterface_error;
    logic         businterface_read;
    logic         businterface_write;
    logic         fault_valid;
    logic [31:0]  fault_address;

    int n_vec  = 0;
    int n_miss = 0;
    logic        m_fault_valid = 1'b0;
    logic [31:0] m_fault_addr  = 32'h0;

    always #5 clock = ~clock;

    bus_interface dut (
        .clock                     (clock),
        .reset                     (reset),
        .cpu_address               (cpu_address),
        .cpu_cycle_width           (cpu_cycle_width),
        .cpu_data_out              (cpu_data_out),
        .cpu_data_in               (cpu_data_in),
        .cpu_read                  (cpu_read),
        .cpu_write                 (cpu_write),
        .businterface_address      (businterface_address),
        .businterface_data_in      (businterface_data_in),
        .businterface_data_out     (businterface_data_out),
        .businterface_data_strobes (businterface_data_strobes),
        .businterface_error        (businterface_error),
        .businterface_read         (businterface_read),
        .businterface_write        (businterface_write),
        .fault_valid               (fault_valid),
        .fault_address             (fault_address)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: the request touches n consecutive byte addresses starting at a;
    // byte address k sits in bits [8*(3-k)+:8] of the bus word.
    task automatic model(output logic err, output logic rd, output logic wr,
                         output logic [3:0] stb, output logic [31:0] dout,
                         output logic [31:0] din, output logic defined);
        int n;
        int a;
        logic req;
        logic aligned;
        a = int'(cpu_address[1:0]);
        case (logic'(1'b0) ? 2'b00 : 2'(cpu_cycle_width))
            2'b00:   n = 1;
            2'b01:   n = 2;
            2'b10:   n = 4;
            default: n = 0;
        endcase
        aligned = (n != 0) && ((a % n) == 0);
        req     = cpu_read | cpu_write;
        err     = req && (!aligned || (cpu_read && cpu_write));
        rd      = cpu_read && !err;
        wr      = cpu_write && !err;
        stb     = 4'b0000;
        dout    = 32'hFFFF_FFFF;
        din     = 32'hFFFF_FFFF;
        defined = aligned || err;
        if (aligned && !err) begin
            for (int i = 0; i < n; i++) begin
                dout[8*(3-(a+i)) +: 8] = cpu_data_out[8*(n-1-i) +: 8];
                din[8*(n-1-i) +: 8]    = businterface_data_in[8*(3-(a+i)) +: 8];
                if (req) stb[3-(a+i)] = 1'b1;
            end
        end
    endtask

    task automatic apply(input logic rst, input logic [31:0] addr, input logic [1:0] w,
                         input logic rd, input logic wr,
                         input logic [31:0] wdata, input logic [31:0] bdata);
        logic e_err, e_rd, e_wr, e_def;
        logic [3:0]  e_stb;
        logic [31:0] e_dout, e_din;
        reset                = rst;
        cpu_address          = addr;
        cpu_cycle_width      = t_cycle_width'(w);
        cpu_read             = rd;
        cpu_write            = wr;
        cpu_data_out         = wdata;
        businterface_data_in = bdata;
        #1;
        model(e_err, e_rd, e_wr, e_stb, e_dout, e_din, e_def);
        chk("error",   32'(businterface_error), 32'(e_err));
        chk("bus_rd",  32'(businterface_read),  32'(e_rd));
        chk("bus_wr",  32'(businterface_write), 32'(e_wr));
        chk("strobes", 32'(businterface_data_strobes), 32'(e_stb));
        chk("waddr",   32'(businterface_address), 32'(addr >> 2));
        if (e_def) begin
            chk("data_out", businterface_data_out, e_dout);
            chk("data_in",  cpu_data_in, e_din);
        end
        @(posedge clock);
        if (rst) begin
            m_fault_valid = 1'b0;
            m_fault_addr  = 32'h0;
        end else if (e_err && !m_fault_valid) begin
            m_fault_valid = 1'b1;
            m_fault_addr  = addr;
        end
        #1;
        chk("fault_valid", 32'(fault_valid), 32'(m_fault_valid));
        chk("fault_addr",  fault_address, m_fault_addr);
    endtask

    initial begin
        reset = 1'b1;
        cpu_address = '0;
        cpu_cycle_width = CW_BYTE;
        cpu_read = 1'b0;
        cpu_write = 1'b0;
        cpu_data_out = '0;
        businterface_data_in = '0;

        apply(1'b1, 32'h0, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("reset_fv", 32'(fault_valid), 32'h0);

        for (int a = 0; a < 4; a++)
            apply(1'b0, 32'(a), 2'b00, 1'b1, 1'b0, 32'h0000_00AB, 32'h1234_5678);
        chk("byte3_in",  cpu_data_in, 32'hFFFF_FF78);
        chk("byte3_out", businterface_data_out, 32'hFFFF_FFAB);
        chk("byte3_stb", 32'(businterface_data_strobes), 32'h1);

        apply(1'b0, 32'h0, 2'b01, 1'b1, 1'b0, 32'h0000_ABCD, 32'h1234_5678);
        chk("word0_in", cpu_data_in, 32'hFFFF_1234);
        apply(1'b0, 32'h2, 2'b01, 1'b1, 1'b0, 32'h0000_ABCD, 32'h1234_5678);
        chk("word2_out", businterface_data_out, 32'hFFFF_ABCD);
        apply(1'b0, 32'h0, 2'b10, 1'b1, 1'b0, 32'hABCD_EF12, 32'h1234_5678);
        chk("long_out", businterface_data_out, 32'hABCD_EF12);

        apply(1'b1, 32'h0, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0);
        apply(1'b0, 32'h1, 2'b01, 1'b1, 1'b0, 32'h0, 32'h1234_5678);
        apply(1'b0, 32'h3, 2'b01, 1'b1, 1'b0, 32'h0, 32'h1234_5678);
        for (int a = 1; a < 4; a++)
            apply(1'b0, 32'(a), 2'b10, 1'b1, 1'b0, 32'h0, 32'h1234_5678);
        chk("misal_err", 32'(businterface_error), 32'h1);

        apply(1'b1, 32'h0, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0);
        apply(1'b0, 32'h2, 2'b10, 1'b1, 1'b0, 32'h0, 32'h0);
        chk("cap_addr", fault_address, 32'h0000_0002);
        apply(1'b0, 32'h1, 2'b01, 1'b1, 1'b0, 32'h0, 32'h0);
        chk("cap_hold", fault_address, 32'h0000_0002);
        apply(1'b1, 32'h0, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("cap_clr", 32'(fault_valid), 32'h0);

        apply(1'b0, 32'h8, 2'b10, 1'b1, 1'b1, 32'h5555_AAAA, 32'h0F0F_0F0F);
        chk("rdwr_out", businterface_data_out, 32'hFFFF_FFFF);
        apply(1'b1, 32'h0, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0);
        apply(1'b0, 32'h10, 2'b11, 1'b0, 1'b1, 32'h5555_AAAA, 32'h0F0F_0F0F);
        chk("rsvd_fa", fault_address, 32'h0000_0010);
        apply(1'b1, 32'h0, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0);
        apply(1'b1, 32'h3, 2'b10, 1'b1, 1'b0, 32'h0, 32'h0);
        chk("rst_prio", 32'(fault_valid), 32'h0);

        for (int k = 0; k < 400; k++) begin
            apply(($urandom_range(0, 29) == 0),
                  $urandom,
                  2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)),
                  $urandom,
                  $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
